// File: rtl/ls_7404.sv
// rtl/ls_7404.sv - hex inverter with combinational outputs plus a clocked observation section
// (registered copy, per-bit change strobes, saturating transition counter).
module ls_7404 #(
   parameter int WIDTH = 6,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] y,
   output logic [WIDTH-1:0] y_q,
   output logic [WIDTH-1:0] chg,
   output logic [CNT_W-1:0] tcnt
);

   localparam int PC_W  = $clog2(WIDTH + 1);
   // Sum is one bit wider than either operand so the saturation compare cannot overflow.
   localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [WIDTH-1:0] y_q_d, y_q_q;
   logic [WIDTH-1:0] chg_d, chg_q;
   logic [CNT_W-1:0] tcnt_d, tcnt_q;
   logic [PC_W-1:0]  pc;
   logic [SUM_W-1:0] sum;

   assign y = ~a;

   always_comb begin
      y_q_d = ~a;
      chg_d = y_q_q ^ y_q_d;
      pc    = '0;
      for (int i = 0; i < WIDTH; i++) begin
         pc = pc + PC_W'(chg_d[i]);
      end
      sum = SUM_W'(tcnt_q) + SUM_W'(pc);
      if (sum > SUM_W'(CNT_MAX)) begin
         tcnt_d = CNT_MAX;
      end else begin
         tcnt_d = sum[CNT_W-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_q_q  <= '1;
         chg_q  <= '0;
         tcnt_q <= '0;
      end else begin
         y_q_q  <= y_q_d;
         chg_q  <= chg_d;
         tcnt_q <= tcnt_d;
      end
   end

   assign y_q  = y_q_q;
   assign chg  = chg_q;
   assign tcnt = tcnt_q;

endmodule

// File: tb/tb_ls_7404.sv
// tb/tb_ls_7404.sv - directed self-checking bench for ls_7404 (default counter and a 4-bit
// saturating counter instance sharing the same inputs).
module tb_ls_7404;

   logic        clk;
   logic        clk_en;
   logic        rst_n;
   logic [5:0]  a;
   logic [5:0]  y, y_q, chg;
   logic [15:0] tcnt;
   logic [5:0]  y4, y_q4, chg4;
   logic [3:0]  tcnt4;

   int checks;
   int errors;
   int exp16;
   int exp4;

   ls_7404 #(.WIDTH(6), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .a(a), .y(y), .y_q(y_q), .chg(chg), .tcnt(tcnt)
   );

   ls_7404 #(.WIDTH(6), .CNT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .a(a), .y(y4), .y_q(y_q4), .chg(chg4), .tcnt(tcnt4)
   );

   initial clk = 1'b0;
   always #5 clk = clk_en ? ~clk : 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      checks = 0;
      errors = 0;
      clk_en = 1'b0;
      rst_n  = 1'b1;

      // Clock idle: combinational path only
      a = 6'b001010; #10;
      chk("y_idle_0a", 32'(y), 32'h35);
      a = 6'b000101; #10;
      chk("y_idle_05", 32'(y), 32'h3A);
      a = 4'b1010; #10;
      chk("y_narrow_drive", 32'(y), 32'h35);

      for (int i = 0; i < 64; i++) begin
         a = 6'(i); #1;
         chk("y_sweep", 32'(y), 32'(63 - i));
         chk("y4_sweep", 32'(y4), 32'(63 - i));
      end
      a = 6'b000000; #1;
      chk("y_all0", 32'(y), 32'h3F);
      a = 6'b111111; #1;
      chk("y_all1", 32'(y), 32'h00);

      // Reset held, clock idle then running
      rst_n = 1'b0;
      a = 6'b101010; #3;
      chk("rst_y_q", 32'(y_q), 32'h3F);
      chk("rst_chg", 32'(chg), 32'h00);
      chk("rst_tcnt", 32'(tcnt), 32'h0);
      chk("rst_y", 32'(y), 32'h15);
      clk_en = 1'b1;
      step(); step();
      chk("rst_clk_y_q", 32'(y_q), 32'h3F);
      chk("rst_clk_chg", 32'(chg), 32'h00);
      chk("rst_clk_tcnt", 32'(tcnt), 32'h0);
      chk("rst_clk_y", 32'(y), 32'h15);

      // Release with a=0: first edge produces no change
      a = 6'b000000;
      rst_n = 1'b1;
      step();
      chk("rel_y_q", 32'(y_q), 32'h3F);
      chk("rel_chg", 32'(chg), 32'h00);
      chk("rel_tcnt", 32'(tcnt), 32'h0);

      a = 6'b000011;
      chk("y_q_latency", 32'(y_q), 32'h3F);
      step();
      chk("two_y_q", 32'(y_q), 32'h3C);
      chk("two_chg", 32'(chg), 32'h03);
      chk("two_tcnt", 32'(tcnt), 32'h2);
      chk("two_chg4", 32'(chg4), 32'h03);
      chk("two_y_q4", 32'(y_q4), 32'h3C);
      step();
      chk("hold_chg", 32'(chg), 32'h00);
      chk("hold_tcnt", 32'(tcnt), 32'h2);

      a = 6'b000111; step();
      chk("c3_chg", 32'(chg), 32'h04);
      chk("c3_tcnt", 32'(tcnt), 32'h3);
      a = 6'b111111; step();
      chk("c6_y_q", 32'(y_q), 32'h00);
      chk("c6_chg", 32'(chg), 32'h38);
      chk("c6_tcnt", 32'(tcnt), 32'h6);
      a = 6'b111110; step();
      chk("c7_chg", 32'(chg), 32'h01);
      chk("c7_tcnt", 32'(tcnt), 32'h7);
      chk("c7_tcnt4", 32'(tcnt4), 32'h7);

      // Mid-run reset between clock edges
      #2 rst_n = 1'b0;
      #1;
      chk("mid_tcnt", 32'(tcnt), 32'h0);
      chk("mid_tcnt4", 32'(tcnt4), 32'h0);
      chk("mid_y_q", 32'(y_q), 32'h3F);
      chk("mid_chg", 32'(chg), 32'h00);
      chk("mid_y", 32'(y), 32'h01);
      a = 6'b010101; #1;
      chk("mid_y_track", 32'(y), 32'h2A);
      chk("mid_y_q_hold", 32'(y_q), 32'h3F);

      // Saturation on the 4-bit counter
      @(negedge clk);
      a = 6'b000000;
      rst_n = 1'b1;
      step();
      chk("sat_start", 32'(tcnt4), 32'h0);
      exp16 = 0;
      exp4  = 0;
      for (int k = 1; k <= 6; k++) begin
         a = (k % 2 == 1) ? 6'b111111 : 6'b000000;
         step();
         exp16 = exp16 + 6;
         exp4  = (exp4 + 6 > 15) ? 15 : exp4 + 6;
         chk("sat_tcnt4", 32'(tcnt4), 32'(exp4));
         chk("sat_tcnt16", 32'(tcnt), 32'(exp16));
         chk("sat_chg", 32'(chg), 32'h3F);
      end
      chk("sat_final", 32'(tcnt4), 32'hF);
      step();
      chk("sat_hold_chg", 32'(chg4), 32'h00);
      chk("sat_hold", 32'(tcnt4), 32'hF);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
